// File: rtl/max_pool_2x2_pkg.sv
// Shared definitions for the 2x2 max-pool block: default pixel width,
// the float total-order key and the +0.0 constant.
package max_pool_2x2_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

   // Maps IEEE-754 bits onto an unsigned key whose order matches float order,
   // with -0.0 ordered below +0.0 so every pair has a unique maximum.
   function automatic logic [31:0] fp32_key(input logic [31:0] x);
      return x[31] ? ~x : (x ^ 32'h8000_0000);
   endfunction

endpackage

// File: rtl/max_pool_2x2_fp32_max.sv
// Combinational two-operand float maximum; the result is always one of the
// operands bit-exactly.
module fp32_max
   import max_pool_2x2_pkg::*;
(
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] max_out
);

   always_comb begin
      max_out = (fp32_key(a_in) >= fp32_key(b_in)) ? a_in : b_in;
   end

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order frame.
// Optional ReLU on the pooled result is enabled by defining MAX_POOL_RELU_EN.
module max_pool_2x2
   import max_pool_2x2_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int IMG_W      = 147,
   parameter int IMG_H      = 147
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  last_out
);

   localparam int OUT_W = IMG_W / 2;
   localparam int OUT_H = IMG_H / 2;
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_LAST_KEPT = CW'(2 * OUT_W - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_LAST_KEPT = RW'(2 * OUT_H - 1);

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] pair_q, pair_d;
   logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  last_out_q, last_out_d;

   logic [DATA_WIDTH-1:0] line_buf_q [OUT_W];
   logic [IW-1:0]         lb_idx;
   logic                  lb_we;
   logic                  row_keep;

   logic [DATA_WIDTH-1:0] max_pair;
   logic [DATA_WIDTH-1:0] max_quad;
   logic [DATA_WIDTH-1:0] pooled;

   fp32_max u_max_pair (
      .a_in    (pair_q),
      .b_in    (pxl_in),
      .max_out (max_pair)
   );

   fp32_max u_max_quad (
      .a_in    (max_pair),
      .b_in    (line_buf_q[lb_idx]),
      .max_out (max_quad)
   );

   always_comb begin
      lb_idx   = IW'(col_q >> 1);
      row_keep = (row_q <= ROW_LAST_KEPT);
   end

   always_comb begin
      pooled = max_quad;
`ifdef MAX_POOL_RELU_EN
      if (max_quad[DATA_WIDTH-1]) begin
         pooled = FP32_POS_ZERO;
      end
`endif
   end

   // Odd columns are never the discarded trailing column, so only the
   // discarded trailing row needs an explicit guard on the buffer write.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      pair_d      = pair_q;
      pxl_out_d   = pxl_out_q;
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
      lb_we       = 1'b0;
      if (valid_in) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            pair_d = pxl_in;
         end else if (!row_q[0]) begin
            lb_we = row_keep;
         end else begin
            valid_out_d = 1'b1;
            pxl_out_d   = pooled;
            last_out_d  = (row_q == ROW_LAST_KEPT) && (col_q == COL_LAST_KEPT);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         pxl_out_q   <= '0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         pair_q      <= pair_d;
         pxl_out_q   <= pxl_out_d;
         valid_out_q <= valid_out_d;
         last_out_q  <= last_out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && lb_we) begin
         line_buf_q[lb_idx] <= max_pair;
      end
   end

   assign pxl_out   = pxl_out_q;
   assign valid_out = valid_out_q;
   assign last_out  = last_out_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized self-checking bench for max_pool_2x2 against a window-level
// reference model; runs a 4x4 and a 5x5 instance from one clock.
module tb_max_pool_2x2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        v4, v5;
   logic [31:0] p4, p5;
   logic [31:0] o4, o5;
   logic        ov4, ov5, ol4, ol5;

   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (v4),
      .pxl_in    (p4),
      .pxl_out   (o4),
      .valid_out (ov4),
      .last_out  (ol4)
   );

   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5)) dut5 (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (v5),
      .pxl_in    (p5),
      .pxl_out   (o5),
      .valid_out (ov5),
      .last_out  (ol5)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] img [25];
   logic [31:0] hold [2];
   logic [32:0] obs_q [$];

   logic [31:0] ramp [16] = '{
      32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
      32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
      32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
      32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
   logic [31:0] ramp_exp [4] = '{
      32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};

   function automatic logic [31:0] refKey(input logic [31:0] x);
      return x[31] ? ~x : (x ^ 32'h8000_0000);
   endfunction

   function automatic logic [31:0] refMax(input logic [31:0] a, input logic [31:0] b);
      return (refKey(a) > refKey(b)) ? a : b;
   endfunction

   function automatic logic [31:0] refPool(input int w, input int r, input int c);
      int base;
      logic [31:0] m;
      base = 2 * r * w + 2 * c;
      m = refMax(refMax(img[base], img[base + 1]), refMax(img[base + w], img[base + w + 1]));
`ifdef MAX_POOL_RELU_EN
      if (m[31]) m = 32'h0;
`endif
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic sampleIdle(input int sel);
      checkOutput("idle_valid", {31'b0, sel ? ov5 : ov4}, 32'h0);
      checkOutput("idle_last",  {31'b0, sel ? ol5 : ol4}, 32'h0);
      checkOutput("idle_hold",  sel ? o5 : o4, hold[sel]);
   endtask

   // gap_mode: 0 = back-to-back, 1 = idle after every pixel, 2 = random idles
   task automatic applyStimulus(input int sel, input int gap_mode, input int npix);
      int w, h, r, c, n_gap;
      logic fire, is_last;
      w = sel ? 5 : 4;
      h = w;
      for (int i = 0; i < npix; i++) begin
         r = i / w;
         c = i % w;
         if (sel != 0) begin v5 = 1'b1; p5 = img[i]; end
         else          begin v4 = 1'b1; p4 = img[i]; end
         @(posedge clk);
         #1;
         v4 = 1'b0;
         v5 = 1'b0;
         fire    = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
         is_last = fire && (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
         if (fire) hold[sel] = refPool(w, r / 2, c / 2);
         checkOutput("valid_out", {31'b0, sel ? ov5 : ov4}, {31'b0, fire});
         checkOutput("pxl_out",   sel ? o5 : o4, hold[sel]);
         checkOutput("last_out",  {31'b0, sel ? ol5 : ol4}, {31'b0, is_last});
         if (sel ? ov5 : ov4) obs_q.push_back({sel ? ol5 : ol4, sel ? o5 : o4});
         n_gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (n_gap) begin
            @(posedge clk);
            #1;
            sampleIdle(sel);
         end
      end
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b1;
      v4 = 1'b1; p4 = $urandom;
      v5 = 1'b1; p5 = $urandom;
      repeat (cycles) @(posedge clk);
      #1;
      hold[0] = 32'h0;
      hold[1] = 32'h0;
      checkOutput("rst_pxl4",   o4, 32'h0);
      checkOutput("rst_valid4", {31'b0, ov4}, 32'h0);
      checkOutput("rst_last4",  {31'b0, ol4}, 32'h0);
      checkOutput("rst_pxl5",   o5, 32'h0);
      checkOutput("rst_valid5", {31'b0, ov5}, 32'h0);
      reset = 1'b0;
      v4 = 1'b0;
      v5 = 1'b0;
   endtask

   task automatic checkRamp(input string tag);
      checkOutput({tag, "_count"}, obs_q.size(), 32'd4);
      for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
         checkOutput({tag, "_value"}, obs_q[k][31:0], ramp_exp[k]);
         checkOutput({tag, "_lastflag"}, {31'b0, obs_q[k][32]}, {31'b0, k == 3});
      end
   endtask

   initial begin
      int n_last;
      reset = 1'b1;
      v4 = 1'b0; v5 = 1'b0;
      p4 = 32'h0; p5 = 32'h0;
      doReset(3);

      for (int i = 0; i < 16; i++) img[i] = ramp[i];
      obs_q.delete();
      applyStimulus(0, 0, 16);
      checkRamp("ramp");

      obs_q.delete();
      applyStimulus(0, 1, 16);
      checkRamp("ramp_gaps");

      applyStimulus(0, 0, 7);
      doReset(1);
      obs_q.delete();
      applyStimulus(0, 0, 16);
      checkRamp("ramp_after_reset");

      obs_q.delete();
      applyStimulus(0, 0, 16);
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      applyStimulus(0, 0, 16);
      checkOutput("b2b_count", obs_q.size(), 32'd8);
      n_last = 0;
      foreach (obs_q[k]) n_last += int'(obs_q[k][32]);
      checkOutput("b2b_last_count", n_last, 32'd2);
      if (obs_q.size() == 8) begin
         checkOutput("b2b_last4", {31'b0, obs_q[3][32]}, 32'h1);
         checkOutput("b2b_last8", {31'b0, obs_q[7][32]}, 32'h1);
      end

      for (int i = 0; i < 25; i++)
         img[i] = (i % 5 == 4 || i / 5 == 4) ? 32'h42C8_0000 : ($urandom & 32'h3FFF_FFFF);
      obs_q.delete();
      applyStimulus(1, 0, 25);
      checkOutput("odd_count", obs_q.size(), 32'd4);
      foreach (obs_q[k]) checkOutput("odd_no_edge", {31'b0, obs_q[k][31:0] == 32'h42C8_0000}, 32'h0);

      for (int i = 0; i < 16; i++) img[i] = $urandom;
      img[0] = 32'hBF80_0000;
      img[1] = 32'h8000_0000;
      img[4] = 32'hC000_0000;
      img[5] = 32'hC040_0000;
      obs_q.delete();
      applyStimulus(0, 0, 16);
      checkOutput("negzero_count", obs_q.size(), 32'd4);
      if (obs_q.size() > 0) begin
`ifdef MAX_POOL_RELU_EN
         checkOutput("negzero", obs_q[0][31:0], 32'h0000_0000);
`else
         checkOutput("negzero", obs_q[0][31:0], 32'h8000_0000);
`endif
      end

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 25; i++) img[i] = $urandom;
         applyStimulus(t % 2, 2, (t % 2 != 0) ? 25 : 16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
